freq_meter: RTL and testbench

Front-end measurement stage of the scope's numeric readout. It counts threshold crossings of the ADC sample stream over a fixed gate window and publishes the result as a saturated 14-bit decimal-range value. The `number` output drives the 14-bit `number` input of the seven-segment display block directly. Crossing detection uses Schmitt hysteresis so that ADC noise near the threshold does not inflate the count.

---
 rtl/scope_pkg.sv | 25 ++
 rtl/schmitt_edge.sv | 73 +++++++
 rtl/freq_meter.sv | 89 ++++++++
 tb/tb_freq_meter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and constants for the scope measurement front end
package scope_pkg;

    localparam int NUMBER_W          = 14;
    localparam int DEFAULT_MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        LOW     = 2'd1,
        HIGH    = 2'd2
    } trk_state_e;

    // Count never exceeds max, so a+inc below max cannot overflow NUMBER_W bits.
    function automatic logic [NUMBER_W-1:0] sat_add(
        input logic [NUMBER_W-1:0] a,
        input logic                inc,
        input logic [NUMBER_W-1:0] max
    );
        if (a >= max) begin
            return max;
        end
        return a + {{(NUMBER_W-1){1'b0}}, inc};
    endfunction

endpackage

// File: rtl/schmitt_edge.sv
// rtl/schmitt_edge.sv - hysteresis level tracker producing a registered rising-edge pulse
module schmitt_edge
    import scope_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int HYST     = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic                edge_o
);

    localparam int             EW       = SAMPLE_W + 1;
    localparam logic [EW-1:0]  CODE_MAX = {1'b0, {SAMPLE_W{1'b1}}};
    localparam logic [EW-1:0]  HYST_E   = EW'(HYST);

    trk_state_e    state_q, state_d;
    logic          edge_q, edge_d;
    logic [EW-1:0] thr_e, smp_e, hi_sum, lo, hi;

    // One extra bit lets the bounds clamp instead of wrapping at either rail.
    always_comb begin
        thr_e  = {1'b0, threshold};
        smp_e  = {1'b0, sample};
        hi_sum = thr_e + HYST_E;
        lo     = (thr_e >= HYST_E) ? (thr_e - HYST_E) : '0;
        hi     = (hi_sum > CODE_MAX) ? CODE_MAX : hi_sum;
    end

    always_comb begin
        state_d = state_q;
        edge_d  = 1'b0;
        if (sample_valid) begin
            case (state_q)
                UNKNOWN: begin
                    if (smp_e <= lo) begin
                        state_d = LOW;
                    end else if (smp_e >= hi) begin
                        state_d = HIGH;
                    end
                end
                LOW: begin
                    if (smp_e >= hi) begin
                        state_d = HIGH;
                        edge_d  = 1'b1;
                    end
                end
                HIGH: begin
                    if (smp_e <= lo) begin
                        state_d = LOW;
                    end
                end
                default: state_d = UNKNOWN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= UNKNOWN;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated crossing counter publishing a saturated count per window
module freq_meter
    import scope_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int HYST        = 16,
    parameter int MAX_COUNT   = DEFAULT_MAX_COUNT
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic [NUMBER_W-1:0] number,
    output logic                overflow,
    output logic                update
);

    localparam int                  GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [NUMBER_W-1:0] MAX_C     = NUMBER_W'(MAX_COUNT);

    logic                edge_pulse;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [NUMBER_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                flag_q, flag_d, flag_inc;
    logic [NUMBER_W-1:0] number_q, number_d;
    logic                ovf_q, ovf_d;
    logic                update_q, update_d;
    logic                terminal;

    schmitt_edge #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_schmitt (
        .clock        (clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .threshold    (threshold),
        .edge_o       (edge_pulse)
    );

    // The terminal cycle's pulse is folded in before publishing, so it lands in the closing window.
    always_comb begin
        terminal = (gate_q == GATE_LAST);
        cnt_inc  = sat_add(cnt_q, edge_pulse, MAX_C);
        flag_inc = flag_q | (edge_pulse & (cnt_inc == MAX_C));

        gate_d   = gate_q + GATE_W'(1);
        cnt_d    = cnt_inc;
        flag_d   = flag_inc;
        number_d = number_q;
        ovf_d    = ovf_q;
        update_d = 1'b0;
        if (terminal) begin
            gate_d   = '0;
            cnt_d    = '0;
            flag_d   = 1'b0;
            number_d = cnt_inc;
            ovf_d    = flag_inc;
            update_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            gate_q   <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            number_q <= '0;
            ovf_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            gate_q   <= gate_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            number_q <= number_d;
            ovf_q    <= ovf_d;
            update_q <= update_d;
        end
    end

    assign number   = number_q;
    assign overflow = ovf_q;
    assign update   = update_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed and randomized checks of freq_meter against a window-level model
module tb_freq_meter;

    localparam int SW   = 12;
    localparam int G    = 100;
    localparam int H    = 16;
    localparam int MAXC = 20;
    localparam int TOP  = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic [SW-1:0] threshold = 12'd2048;
    logic [13:0]   number;
    logic          overflow;
    logic          update;

    freq_meter #(
        .SAMPLE_W    (SW),
        .GATE_CYCLES (G),
        .HYST        (H),
        .MAX_COUNT   (MAXC)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .threshold    (threshold),
        .number       (number),
        .overflow     (overflow),
        .update       (update)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: level 0=unknown 1=low 2=high; raw crossings kept unbounded and saturated only when published.
    int m_lvl = 0;
    int m_pulse = 0;
    int m_gate = 0;
    int m_raw = 0;
    int e_num = 0;
    int e_ovf = 0;
    int e_upd = 0;

    int upd_cnt = 0;
    int last_num = -1;
    int last_ovf = -1;
    int phase = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int lo, hi, s, np;
        if (!resetn) begin
            m_lvl = 0; m_pulse = 0; m_gate = 0; m_raw = 0;
            e_num = 0; e_ovf = 0; e_upd = 0;
            return;
        end
        m_raw += m_pulse;
        if (m_gate == G - 1) begin
            e_num  = (m_raw > MAXC) ? MAXC : m_raw;
            e_ovf  = (m_raw >= MAXC) ? 1 : 0;
            e_upd  = 1;
            m_raw  = 0;
            m_gate = 0;
        end else begin
            m_gate++;
            e_upd = 0;
        end
        lo = int'(threshold) - H;
        if (lo < 0) lo = 0;
        hi = int'(threshold) + H;
        if (hi > TOP) hi = TOP;
        np = 0;
        if (sample_valid) begin
            s = int'(sample);
            if (m_lvl == 0) begin
                if (s <= lo) m_lvl = 1;
                else if (s >= hi) m_lvl = 2;
            end else if (m_lvl == 1) begin
                if (s >= hi) begin m_lvl = 2; np = 1; end
            end else begin
                if (s <= lo) m_lvl = 1;
            end
        end
        m_pulse = np;
    endtask

    task automatic step(input logic v, input logic [SW-1:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clock);
        model_edge();
        #1;
        chk("number", 32'(number), 32'(e_num));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("update", 32'(update), 32'(e_upd));
        if (update === 1'b1) begin
            upd_cnt++;
            last_num = int'(number);
            last_ovf = int'(overflow);
        end
    endtask

    task automatic run_sq(input int half, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, ((phase / half) % 2 == 1) ? 12'd3000 : 12'd1000);
            phase++;
        end
    endtask

    initial begin
        int first_upd;
        int since;

        // Reset and flat input.
        resetn = 1'b0;
        step(1'b1, 12'd0);
        step(1'b1, 12'd0);
        chk("reset_number", 32'(number), 32'd0);
        chk("reset_update", 32'(update), 32'd0);
        resetn = 1'b1;
        upd_cnt = 0;
        first_upd = -1;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 12'd0);
            if (update === 1'b1 && first_upd < 0) first_upd = i + 1;
        end
        chk("flat_first_update_cycle", 32'(first_upd), 32'd100);
        chk("flat_update_count", 32'(upd_cnt), 32'd3);
        chk("flat_number", 32'(last_num), 32'd0);
        chk("flat_overflow", 32'(last_ovf), 32'd0);

        // Square wave, period 10.
        upd_cnt = 0;
        phase = 0;
        run_sq(5, 300);
        chk("sq10_update_count", 32'(upd_cnt), 32'd3);
        chk("sq10_number", 32'(last_num), 32'd10);
        chk("sq10_overflow", 32'(last_ovf), 32'd0);

        // Noise inside the hysteresis band.
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 12'd2040 : 12'd2056);
        chk("noise_number", 32'(last_num), 32'd0);

        // Saturation then recovery.
        phase = 0;
        run_sq(1, 200);
        chk("sat_number", 32'(last_num), 32'(MAXC));
        chk("sat_overflow", 32'(last_ovf), 32'd1);
        for (int i = 0; i < 200; i++) step(1'b1, 12'd0);
        chk("post_sat_number", 32'(last_num), 32'd0);
        chk("post_sat_overflow", 32'(last_ovf), 32'd0);

        // Edge pulse on the terminal gate cycle.
        for (int k = 0; k < 2 * G && m_gate != G - 2; k++) step(1'b1, 12'd0);
        upd_cnt = 0;
        step(1'b1, 12'd3000);
        step(1'b1, 12'd3000);
        chk("term_update_seen", 32'(upd_cnt), 32'd1);
        chk("term_number", 32'(last_num), 32'd1);
        for (int i = 0; i < G; i++) step(1'b1, 12'd3000);
        chk("term_next_number", 32'(last_num), 32'd0);

        // Mid-window reset.
        phase = 0;
        run_sq(5, G);
        for (int k = 0; k < 2 * G && m_gate != 57; k++) run_sq(5, 1);
        chk("pre_reset_number", 32'(number), 32'd10);
        resetn = 1'b0;
        step(1'b1, 12'd0);
        resetn = 1'b1;
        chk("midreset_number", 32'(number), 32'd0);
        chk("midreset_overflow", 32'(overflow), 32'd0);
        since = -1;
        for (int i = 0; i < 2 * G && since < 0; i++) begin
            step(1'b1, 12'd0);
            if (update === 1'b1) since = i + 1;
        end
        chk("midreset_next_update", 32'(since), 32'd100);

        // Randomized windows, including rail thresholds and mid-window threshold changes.
        for (int w = 0; w < 30; w++) begin
            case ($urandom_range(0, 4))
                0: threshold = 12'd0;
                1: threshold = 12'd8;
                2: threshold = 12'd4095;
                3: threshold = 12'd4085;
                default: threshold = 12'($urandom_range(0, TOP));
            endcase
            for (int c = 0; c < G; c++) begin
                int s;
                if (c == 50 && $urandom_range(0, 1) == 1) threshold = 12'($urandom_range(0, TOP));
                s = int'(threshold) + int'($urandom_range(0, 80)) - 40;
                if (s < 0) s = 0;
                if (s > TOP) s = TOP;
                if ($urandom_range(0, 9) == 0) s = int'($urandom_range(0, TOP));
                step($urandom_range(0, 3) != 0, 12'(s));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
